// File: rtl/log_sine_pkg.sv
// Shared constants, FSM state type and width helpers for the log-sine voice mixer.
package log_sine_pkg;

   localparam int unsigned ROM_DEPTH    = 256;
   localparam int unsigned MAG_W        = 12;
   localparam int unsigned VOICE_W      = 13;
   localparam int unsigned OCT_LIMIT    = 16;
   localparam int unsigned DRAIN_CYCLES = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Mix width grows by one bit per doubling of voices so the sum never wraps.
   function automatic int unsigned mix_width(input int unsigned num_ch);
      return VOICE_W + $clog2(num_ch);
   endfunction

   // Channel-select width; kept at least one bit for the single-voice build.
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/log_sine_voice_mixer_log_to_linear.sv
// Log-to-linear converter: exp table lookup, octave shift, sign and zero force.
// Two-cycle latency from in_* to out_*.
module log_to_linear
   import log_sine_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [11:0]        in_a,
   input  logic               in_sign,
   input  logic               in_zero,
   output logic               out_valid,
   output logic [VOICE_W-1:0] out_value
);

   logic [9:0]         pow_data;
   logic               s3_valid_q, s3_valid_d;
   logic [3:0]         s3_shift_q, s3_shift_d;
   logic               s3_sign_q, s3_sign_d;
   logic               s3_zero_q, s3_zero_d;
   logic               s4_valid_q, s4_valid_d;
   logic [VOICE_W-1:0] s4_value_q, s4_value_d;
   logic [MAG_W-1:0]   mag;

   powerROM u_power_rom (
      .clk  (clk),
      .addr (~in_a[7:0]),
      .data (pow_data)
   );

   // Align control with the table read, then build the signed voice value.
   always_comb begin
      s3_valid_d = in_valid;
      s3_shift_d = in_a[11:8];
      s3_sign_d  = in_sign;
      s3_zero_d  = in_zero;
      mag        = {1'b1, pow_data, 1'b0} >> s3_shift_q;
      s4_valid_d = s3_valid_q;
      s4_value_d = s3_sign_q ? VOICE_W'(-{1'b0, mag}) : {1'b0, mag};
      if (s3_zero_q) begin
         s4_value_d = '0;
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s3_valid_q <= 1'b0;
         s3_shift_q <= '0;
         s3_sign_q  <= 1'b0;
         s3_zero_q  <= 1'b0;
         s4_valid_q <= 1'b0;
         s4_value_q <= '0;
      end else begin
         s3_valid_q <= s3_valid_d;
         s3_shift_q <= s3_shift_d;
         s3_sign_q  <= s3_sign_d;
         s3_zero_q  <= s3_zero_d;
         s4_valid_q <= s4_valid_d;
         s4_value_q <= s4_value_d;
      end
   end

   assign out_valid = s4_valid_q;
   assign out_value = s4_value_q;

endmodule

// File: rtl/logsineROM.sv
// Quarter-wave log-sine table: L[i] = round(-log2(sin((i+0.5)*pi/512)) * 256).
// Registered output, one cycle read latency.
module logsineROM (
   input  logic       clk,
   input  logic [7:0] addr,
   output logic [15:0] data
);

   function automatic int lsin_entry(input int i);
      real x;
      x = $sin((real'(i) + 0.5) * 3.14159265358979 / 512.0);
      return $rtoi(-($ln(x) / $ln(2.0)) * 256.0 + 0.5);
   endfunction

   logic [15:0] rom [256];
   logic [15:0] data_q;

   for (genvar i = 0; i < 256; i++) begin : g_rom
      localparam int VAL = lsin_entry(i);
      assign rom[i] = 16'(VAL);
   end

   // Synchronous table read.
   always_ff @(posedge clk) begin
      data_q <= rom[addr];
   end

   assign data = data_q;

endmodule

// File: rtl/powerROM.sv
// Exponential table: P[i] = round((2^(i/256) - 1) * 1024).
// Registered output, one cycle read latency.
module powerROM (
   input  logic       clk,
   input  logic [7:0] addr,
   output logic [9:0] data
);

   function automatic int pow_entry(input int i);
      return $rtoi(($pow(2.0, real'(i) / 256.0) - 1.0) * 1024.0 + 0.5);
   endfunction

   logic [9:0] rom [256];
   logic [9:0] data_q;

   for (genvar i = 0; i < 256; i++) begin : g_rom
      localparam int VAL = pow_entry(i);
      assign rom[i] = 10'(VAL);
   end

   // Synchronous table read.
   always_ff @(posedge clk) begin
      data_q <= rom[addr];
   end

   assign data = data_q;

endmodule

// File: rtl/log_sine_voice_mixer.sv
// Time-multiplexed log-domain sine oscillator bank and mixer.
// One mixed sample per sample_tick; channels issued one per cycle into a
// six-stage pipeline (issue, log-sine read, attenuate, exp read, shift/sign, sum).
// Optional LOGSINE_PHASE_SYNC_EN: a cfg write that enables a disabled channel
// also zeroes its phase for phase-coherent note start.
module log_sine_voice_mixer
   import log_sine_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned PHASE_FRAC = 16,
   parameter int unsigned STEP_W     = 26,
   parameter int unsigned ATT_W      = 13
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_tick,
   input  logic                         cfg_we,
   input  logic [ch_width(NUM_CH)-1:0]  cfg_ch,
   input  logic [STEP_W-1:0]            cfg_step,
   input  logic [ATT_W-1:0]             cfg_atten,
   input  logic                         cfg_en,
   output logic [mix_width(NUM_CH)-1:0] mix_out,
   output logic                         mix_valid,
   output logic                         busy,
   output logic                         overrun
);

   localparam int unsigned PW    = PHASE_FRAC + 10;
   localparam int unsigned CH_W  = ch_width(NUM_CH);
   localparam int unsigned MIX_W = mix_width(NUM_CH);
   localparam int unsigned A_W   = ATT_W + 1;

   state_e             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [MIX_W-1:0]   acc_q, acc_d, mix_q, mix_d;
   logic               mix_valid_q, mix_valid_d;
   logic               overrun_q, overrun_d;
   logic               clear_acc;

   logic [PW-1:0]      phase_q [NUM_CH];
   logic [PW-1:0]      phase_d [NUM_CH];
   logic [STEP_W-1:0]  step_q  [NUM_CH];
   logic [STEP_W-1:0]  step_d  [NUM_CH];
   logic [ATT_W-1:0]   atten_q [NUM_CH];
   logic [ATT_W-1:0]   atten_d [NUM_CH];
   logic [NUM_CH-1:0]  en_q, en_d;

   logic               issue;
   logic [CH_W-1:0]    idx;

   logic               s0_valid_q, s0_valid_d;
   logic [7:0]         s0_addr_q, s0_addr_d;
   logic               s0_sign_q, s0_sign_d;
   logic [ATT_W-1:0]   s0_atten_q, s0_atten_d;
   logic               s0_en_q, s0_en_d;
   logic               s1_valid_q, s1_valid_d;
   logic               s1_sign_q, s1_sign_d;
   logic [ATT_W-1:0]   s1_atten_q, s1_atten_d;
   logic               s1_en_q, s1_en_d;
   logic [15:0]        lsin_data;
   logic [A_W-1:0]     a_sum;
   logic               s2_valid_q, s2_valid_d;
   logic [11:0]        s2_a_q, s2_a_d;
   logic               s2_sign_q, s2_sign_d;
   logic               s2_zero_q, s2_zero_d;
   logic               v_valid;
   logic [VOICE_W-1:0] v_value;

   assign issue = (state_q == ST_RUN);
   assign idx   = cnt_q[CH_W-1:0];

   // Frame sequencer: issue every channel, let the pipeline drain, publish the sum.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      overrun_d   = overrun_q;
      clear_acc   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_tick) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               clear_acc = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_q == 5'(NUM_CH - 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 5'(DRAIN_CYCLES - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         ST_DONE: begin
            mix_d       = acc_q;
            mix_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (sample_tick && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   // Channel register file: phase advance on issue, configuration writes at any time.
   always_comb begin
      phase_d = phase_q;
      step_d  = step_q;
      atten_d = atten_q;
      en_d    = en_q;
      if (issue) begin
         phase_d[idx] = phase_q[idx] + PW'(step_q[idx]);
      end
      if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
         step_d[cfg_ch]  = cfg_step;
         atten_d[cfg_ch] = cfg_atten;
         en_d[cfg_ch]    = cfg_en;
`ifdef LOGSINE_PHASE_SYNC_EN
         // Applied after the issue increment so a coincident zeroing wins.
         if (cfg_en && !en_q[cfg_ch]) begin
            phase_d[cfg_ch] = '0;
         end
`endif
      end
   end

   // Datapath stages S0..S2 and the S5 accumulator.
   always_comb begin
      s0_valid_d = issue;
      s0_sign_d  = phase_q[idx][PW-1];
      s0_addr_d  = phase_q[idx][PW-2] ? ~phase_q[idx][PW-3:PHASE_FRAC]
                                      :  phase_q[idx][PW-3:PHASE_FRAC];
      s0_atten_d = atten_q[idx];
      s0_en_d    = en_q[idx];
      s1_valid_d = s0_valid_q;
      s1_sign_d  = s0_sign_q;
      s1_atten_d = s0_atten_q;
      s1_en_d    = s0_en_q;
      a_sum      = A_W'(lsin_data) + A_W'(s1_atten_q);
      s2_valid_d = s1_valid_q;
      s2_a_d     = a_sum[11:0];
      s2_sign_d  = s1_sign_q;
      s2_zero_d  = (a_sum[A_W-1:8] >= (A_W-8)'(OCT_LIMIT)) || !s1_en_q;
      acc_d      = acc_q;
      if (clear_acc) begin
         acc_d = '0;
      end else if (v_valid) begin
         acc_d = acc_q + MIX_W'($signed(v_value));
      end
   end

   logsineROM u_logsine_rom (
      .clk  (clk),
      .addr (s0_addr_q),
      .data (lsin_data)
   );

   log_to_linear u_log_to_linear (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s2_valid_q),
      .in_a      (s2_a_q),
      .in_sign   (s2_sign_q),
      .in_zero   (s2_zero_q),
      .out_valid (v_valid),
      .out_value (v_value)
   );

   // State, channel and pipeline registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            phase_q[i] <= '0;
            step_q[i]  <= '0;
            atten_q[i] <= '0;
         end
         en_q       <= '0;
         s0_valid_q <= 1'b0;
         s0_addr_q  <= '0;
         s0_sign_q  <= 1'b0;
         s0_atten_q <= '0;
         s0_en_q    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_atten_q <= '0;
         s1_en_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_a_q     <= '0;
         s2_sign_q  <= 1'b0;
         s2_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         overrun_q   <= overrun_d;
         phase_q     <= phase_d;
         step_q      <= step_d;
         atten_q     <= atten_d;
         en_q        <= en_d;
         s0_valid_q  <= s0_valid_d;
         s0_addr_q   <= s0_addr_d;
         s0_sign_q   <= s0_sign_d;
         s0_atten_q  <= s0_atten_d;
         s0_en_q     <= s0_en_d;
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_atten_q  <= s1_atten_d;
         s1_en_q     <= s1_en_d;
         s2_valid_q  <= s2_valid_d;
         s2_a_q      <= s2_a_d;
         s2_sign_q   <= s2_sign_d;
         s2_zero_q   <= s2_zero_d;
      end
   end

   assign mix_out   = mix_q;
   assign mix_valid = mix_valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign overrun   = overrun_q;

endmodule

// File: doc/log_sine_voice_mixer.md
Name: log_sine_voice_mixer

Overview:
- Time-multiplexed, multi-channel log-domain sine oscillator and mixer.
- Generalised successor of the single-voice log-sine frequency generator.
- Per-channel phase accumulators, per-channel log-domain attenuation, a two's-complement signed output and a summed mix.
- Sits between the register/control interface and the DAC/PWM output stage; one mixed sample is produced per sample_tick.

Parameters:
- NUM_CH, 4, number of voices (1..16).
- PHASE_FRAC, 16, fractional phase bits below the 10-bit sine index.
- STEP_W, 26, phase-step width, ≤ PHASE_FRAC+10.
- ATT_W, 13, attenuation width; units 1/256 octave.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  start one mix frame.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_step  in  STEP_W  phase increment per frame.
- cfg_atten  in  ATT_W  attenuation.
- cfg_en  in  1  channel enable.
- mix_out  out  13+$clog2(NUM_CH)  signed sum of voices.
- mix_valid  out  1  one-cycle strobe; mix_out updated.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: sample_tick arrived while busy.

Behaviour:
- Reset: all phases, steps, attens, enables, mix_out, mix_valid, busy, overrun = 0.
- Phase fields, phase width PW = PHASE_FRAC+10:
  - bit PW-1 = sign.
  - bit PW-2 = mirror.
  - bits [PW-3:PHASE_FRAC] = 8-bit index.
  - Quarter-wave address = index when mirror=0, else index^8'hFF.
- FSM IDLE/RUN/DRAIN/DONE:
  - IDLE: sample_tick → RUN, clear accumulator.
  - RUN: issue channel 0..NUM_CH-1, one per cycle; after the last issue → DRAIN.
  - DRAIN: wait 5 cycles for the pipeline to empty → DONE.
  - DONE: register mix_out, pulse mix_valid, → IDLE.
  - busy = 1 in RUN, DRAIN and DONE.
- Latency: mix_valid is high exactly NUM_CH+6 cycles after the tick is sampled. Back-to-back ticks are accepted from the cycle after DONE.
- Pipeline stages:
  - S0 issue: read phase, step, atten, en; form ROM address; phase += step (modulo 2^PW). The sample uses the pre-increment phase.
  - S1: logsineROM lookup (synchronous, 16-bit L).
  - S2: A = L[15:0] + atten, unsigned, ATT_W+1 bits. Zero flag set if A[top:8] ≥ 16 or en=0.
  - S3: powerROM[~A[7:0]] lookup.
  - S4: mag = ((P|1024)<<1) >> A[11:8], 12-bit unsigned. Value = sign ? -mag : mag (true two's complement, 13-bit). Forced to 0 if zero flag is set.
  - S5: accumulator += sign-extended value.
- Disabled channels contribute 0; their phase still advances.
- cfg write: takes effect at the channel's next issue. A write in the same cycle the channel is issued is not seen until the next frame. Writes are accepted in any state.
- sample_tick while busy: ignored, sets overrun. overrun is cleared only by reset.
- Mix width: 13+$clog2(NUM_CH) bits, so the sum never overflows; no saturation.
- reset mid-frame: FSM → IDLE, pipeline valids cleared, no mix_valid, all phases zeroed.

Optional Feature:
- Macro: LOGSINE_PHASE_SYNC_EN.
- Defined: a cfg write with cfg_en rising 0→1 also zeroes that channel's phase. This allows phase-coherent note start; if the write coincides with the channel's issue, the zeroing wins over the increment.
- Undefined: phase is never touched by cfg writes and runs freely from reset.

Decomposition:
- Package log_sine_pkg holds:
  - ROM depth 256.
  - Magnitude width 12 and voice width 13.
  - The octave shift limit 16.
  - FSM state enum.
  - A function computing mix width from NUM_CH.
- One sub-module, log_to_linear: S3–S4 (powerROM instance, shift, sign, zero force), 2-cycle latency.
- The existing logsineROM and powerROM are instantiated unchanged.

Test Plan:
- Reset then one tick, all channels disabled → mix_valid at cycle NUM_CH+6, mix_out=0, overrun=0.
- Channel 0 en, step=0x1000000 (quarter cycle), atten=0; 4 ticks → samples m0, +peak, -m0, -peak. peak equals the model value for address 255; sample 4 is exactly -(sample 2).
- Same as above with atten=0x100 → every sample = floor(mag/2) with original sign; atten=0x1000 → all 0.
- 4 channels, identical config → mix_out = 4× the single-channel value; at peak, mix_out fits in 15 bits signed with no wrap.
- sample_tick pulsed at cycle 2 of a frame → ignored, overrun=1, mix_valid count unchanged; a reset pulse mid-frame → no mix_valid, phases 0.
- LOGSINE_PHASE_SYNC_EN: run channel 0, disable it, re-enable via cfg → next issued sample has phase 0; without the macro, phase continues.
